pwm_deadtime: RTL and testbench

PWM_DEADTIME -- requirements
Module: pwm_deadtime

---
 rtl/pwm_deadtime.sv | 157 +++++++++++++++
 tb/tb_pwm_deadtime.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary gate-drive generator with dead-time insertion.
// Splits a raw PWM stream into high-side / low-side drives with a
// guaranteed both-off interval of max(DT_IN,1) CE ticks between
// opposite conductions. All outputs are registered.
// Optional feature: define PWM_DT_FAULT_EN to enable the sticky fault
// input (FAULT / FAULT_CLR / FAULT_O). Without it the fault inputs are
// ignored and FAULT_O stays 0.
module pwm_deadtime #(
    parameter int DTW = 8
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           CE,
    input  logic           PWM_IN,
    input  logic [DTW-1:0] DT_IN,
    input  logic           FAULT,
    input  logic           FAULT_CLR,
    output logic           PWM_H,
    output logic           PWM_L,
    output logic           FAULT_O
);

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_LOW  = 3'd1,
        ST_DT_R = 3'd2,
        ST_HIGH = 3'd3,
        ST_DT_F = 3'd4,
        ST_FLT  = 3'd5
    } state_t;

    localparam logic [DTW-1:0] CNT_ZERO = {DTW{1'b0}};
    localparam logic [DTW-1:0] CNT_ONE  = {{(DTW-1){1'b0}}, 1'b1};

    state_t         state_r;
    state_t         state_s;
    logic [DTW-1:0] cnt_r;
    logic [DTW-1:0] cnt_s;
    logic           pwm_h_r;
    logic           pwm_l_r;
    logic           fault_o_r;
    logic           fault_req_s;
    logic           fault_clr_s;
    logic           fault_en_s;

`ifdef PWM_DT_FAULT_EN
    assign fault_req_s = FAULT;
    assign fault_clr_s = FAULT_CLR;
    assign fault_en_s  = 1'b1;
`else
    // Fault pins are deliberately inert in this build.
    logic unused_fault_s;
    assign unused_fault_s = FAULT | FAULT_CLR;
    assign fault_req_s    = 1'b0;
    assign fault_clr_s    = 1'b0;
    assign fault_en_s     = 1'b0;
`endif

    // Next-state and dead-time counter logic; fault overrides CE gating.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        if (fault_req_s) begin
            state_s = ST_FLT;
            cnt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_OFF: begin
                    if (CE) begin
                        state_s = ST_DT_F;
                        cnt_s   = DT_IN;
                    end else begin
                        state_s = ST_OFF;
                    end
                end
                ST_LOW: begin
                    if (CE && PWM_IN) begin
                        state_s = ST_DT_R;
                        cnt_s   = DT_IN;
                    end else begin
                        state_s = ST_LOW;
                    end
                end
                ST_HIGH: begin
                    if (CE && !PWM_IN) begin
                        state_s = ST_DT_F;
                        cnt_s   = DT_IN;
                    end else begin
                        state_s = ST_HIGH;
                    end
                end
                ST_DT_R: begin
                    if (!CE) begin
                        state_s = ST_DT_R;
                    end else if (!PWM_IN) begin
                        state_s = ST_LOW;
                        cnt_s   = CNT_ZERO;
                    end else if (cnt_r <= CNT_ONE) begin
                        // A zero load also ends here, so DT_IN=0 acts as 1.
                        state_s = ST_HIGH;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s   = cnt_r - CNT_ONE;
                    end
                end
                ST_DT_F: begin
                    if (!CE) begin
                        state_s = ST_DT_F;
                    end else if (PWM_IN) begin
                        state_s = ST_HIGH;
                        cnt_s   = CNT_ZERO;
                    end else if (cnt_r <= CNT_ONE) begin
                        state_s = ST_LOW;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        cnt_s   = cnt_r - CNT_ONE;
                    end
                end
                ST_FLT: begin
                    if (fault_clr_s) begin
                        state_s = ST_OFF;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = ST_FLT;
                    end
                end
                default: begin
                    state_s = ST_OFF;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counter and gate-drive registers; outputs decode the next state
    // so they move on the same edge that samples the qualifying inputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_OFF;
            cnt_r     <= CNT_ZERO;
            pwm_h_r   <= 1'b0;
            pwm_l_r   <= 1'b0;
            fault_o_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            pwm_h_r   <= (state_s == ST_HIGH);
            pwm_l_r   <= (state_s == ST_LOW);
            fault_o_r <= (state_s == ST_FLT) & fault_en_s;
        end
    end

    assign PWM_H   = pwm_h_r;
    assign PWM_L   = pwm_l_r;
    assign FAULT_O = fault_o_r;

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: scoreboard bench for pwm_deadtime. A behavioural model
// predicts the registered outputs for every driven cycle; predictions are
// queued at drive time and compared after the following clock edge.
module tb_pwm_deadtime;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CE;
    logic       PWM_IN;
    logic [7:0] DT_IN;
    logic       FAULT;
    logic       FAULT_CLR;
    logic       PWM_H;
    logic       PWM_L;
    logic       FAULT_O;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];

    // model: phase 0 = off, 1 = conducting, 2 = dead time, 3 = fault
    int m_phase = 0;
    bit m_side  = 1'b0;   // conducting side, or target side while dead
    int m_rem   = 0;      // dead ticks still to come after the current one

    pwm_deadtime #(.DTW(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CE        (CE),
        .PWM_IN    (PWM_IN),
        .DT_IN     (DT_IN),
        .FAULT     (FAULT),
        .FAULT_CLR (FAULT_CLR),
        .PWM_H     (PWM_H),
        .PWM_L     (PWM_L),
        .FAULT_O   (FAULT_O)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit c, input bit p, input int d,
                              input bit f, input bit fc);
        int dd;
        dd = (d == 0) ? 1 : d;
        if (r) begin
            m_phase = 0;
        end
`ifdef PWM_DT_FAULT_EN
        else if (f) begin
            m_phase = 3;
        end else if (m_phase == 3) begin
            if (fc) m_phase = 0;
        end
`endif
        else if (c) begin
            case (m_phase)
                0: begin m_phase = 2; m_side = 1'b0; m_rem = dd - 1; end
                1: if (p != m_side) begin m_phase = 2; m_side = p; m_rem = dd - 1; end
                2: begin
                    if (p != m_side) begin
                        m_phase = 1;
                        m_side  = p;
                    end else if (m_rem == 0) begin
                        m_phase = 1;
                    end else begin
                        m_rem--;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input bit r, input bit c, input bit p, input logic [7:0] d,
                        input bit f, input bit fc);
        logic [2:0] e;
        RST = r; CE = c; PWM_IN = p; DT_IN = d; FAULT = f; FAULT_CLR = fc;
        model_step(r, c, p, int'(d), f, fc);
        exp_q.push_back({(m_phase == 1) && m_side, (m_phase == 1) && !m_side, m_phase == 3});
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check_val("pwm_h", PWM_H, e[2]);
        check_val("pwm_l", PWM_L, e[1]);
        check_val("fault_o", FAULT_O, e[0]);
        check_val("h_and_l", PWM_H & PWM_L, 0);
    endtask

    // Hold inputs and count both-off clocks until either side conducts.
    task automatic count_dead(input bit p, input logic [7:0] d, input int ce_period,
                              input int bound, output int n);
        n = 0;
        for (int i = 0; i < bound; i++) begin
            step(1'b0, (i % ce_period) == 0, p, d, 1'b0, 1'b0);
            if (PWM_H || PWM_L) break;
            n++;
        end
    endtask

    initial begin
        int  n;
        bit  h_seen;
        bit  rc, rp, rf, rfc, rr;
        logic [7:0] rd;

        // reset wins over CE, FAULT and clear
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 1'b1);

        // power-up: OFF -> DT_F -> LOW
        repeat (6) step(1'b0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b0);
        check_val("init_low", PWM_L, 1);

        // DT_IN=3, CE every clock, rising edge: 3 dead clocks then high
        count_dead(1'b1, 8'd3, 1, 20, n);
        check_val("dt3_off", n, 3);
        check_val("dt3_high", PWM_H, 1);

        // 100% duty holds HIGH
        repeat (20) step(1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0);
        check_val("hold_high", PWM_H, 1);

        // DT_IN=4, CE every 3rd clock, falling edge: 12 dead clocks then low
        count_dead(1'b0, 8'd4, 3, 60, n);
        check_val("dt4_ce3_off", n, 12);
        check_val("dt4_ce3_low", PWM_L, 1);

        // 0% duty holds LOW
        repeat (20) step(1'b0, 1'b1, 1'b0, 8'd4, 1'b0, 1'b0);
        check_val("hold_low", PWM_L, 1);

        // DT_IN=0, toggling every 5 ticks: 8 edges, one dead clock each
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, ((i / 5) % 2) == 0, 8'd0, 1'b0, 1'b0);
            if (!PWM_H && !PWM_L) n++;
        end
        check_val("dt0_off_total", n, 8);

        // aborted pulse in DT_R with DT_IN=6
        h_seen = 1'b0;
        step(1'b0, 1'b1, 1'b1, 8'd6, 1'b0, 1'b0); h_seen |= PWM_H;
        step(1'b0, 1'b1, 1'b1, 8'd6, 1'b0, 1'b0); h_seen |= PWM_H;
        step(1'b0, 1'b1, 1'b0, 8'd6, 1'b0, 1'b0); h_seen |= PWM_H;
        check_val("abort_low", PWM_L, 1);
        check_val("abort_no_h", h_seen, 0);

        // CE=0 freezes everything
        repeat (10) step(1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
        check_val("ce0_hold", PWM_L, 1);

        // fault pulse in HIGH with CE=0, then clear
        count_dead(1'b1, 8'd2, 1, 20, n);
        step(1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0);
`ifdef PWM_DT_FAULT_EN
        check_val("flt_h", PWM_H, 0);
        check_val("flt_flag", FAULT_O, 1);
`else
        check_val("flt_ignored_h", PWM_H, 1);
        check_val("flt_ignored_flag", FAULT_O, 0);
`endif
        repeat (3) step(1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'd2, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'd2, 1'b0, 1'b1);
        check_val("clr_flag", FAULT_O, 0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b0);
        check_val("clr_to_low", PWM_L, 1);

        // reset in DT_F with CNT=5
        count_dead(1'b1, 8'd5, 1, 20, n);
        step(1'b0, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'd5, 1'b1, 1'b0);
        check_val("rst_dt_h", PWM_H, 0);
        check_val("rst_dt_l", PWM_L, 0);
        check_val("rst_dt_flag", FAULT_O, 0);
        repeat (8) step(1'b0, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0);
        check_val("rst_recover_low", PWM_L, 1);

        // maximum dead time
        count_dead(1'b1, 8'd255, 1, 300, n);
        check_val("dt255_off", n, 255);
        check_val("dt255_high", PWM_H, 1);

        // randomised traffic, DT_IN changing freely mid-interval
        rp = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rc  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) rp = ~rp;
            rd  = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 6));
            rf  = ($urandom_range(0, 40) == 0);
            rfc = ($urandom_range(0, 5) == 0);
            rr  = ($urandom_range(0, 80) == 0);
            step(rr, rc, rp, rd, rf, rfc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
